// File: rtl/mul_scheduler_pkg.sv
// Shared types and defaults for the multiplier scheduler: requester ids,
// the tag carried alongside each operation, and the default geometry.
package mul_scheduler_pkg;

  localparam int LAT_DEFAULT = 4;
  localparam int W_DEFAULT   = 8;
  localparam int ID_W        = 1;

  typedef enum logic [ID_W-1:0] {
    ID_MANUAL = 1'b0,
    ID_SWEEP  = 1'b1
  } id_e;

  typedef struct packed {
    logic valid;
    id_e  id;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{valid: 1'b0, id: ID_MANUAL};

  // Map a one-hot grant vector onto the requester id it represents.
  function automatic id_e gnt_to_id(input logic [1:0] gnt);
    return (gnt[1] && !gnt[0]) ? ID_SWEEP : ID_MANUAL;
  endfunction

endpackage

// File: rtl/mul_scheduler_if.sv
// Bundle of requester handshakes, result returns and multiplier operand/product
// wires; the scheduler sits on the slave side, requesters and multiplier on master.
interface mul_scheduler_if #(parameter int W = 8);

  logic           req0_valid;
  logic           req0_ready;
  logic [W-1:0]   req0_x;
  logic [W-1:0]   req0_y;
  logic           req1_valid;
  logic           req1_ready;
  logic [W-1:0]   req1_x;
  logic [W-1:0]   req1_y;

  logic           res0_valid;
  logic [2*W-1:0] res0_ans;
  logic           res1_valid;
  logic [2*W-1:0] res1_ans;

  logic [W-1:0]   mul_px;
  logic [W-1:0]   mul_py;
  logic [2*W-1:0] mul_ans;

  logic           busy;

  modport slave (
    input  req0_valid, req0_x, req0_y,
    input  req1_valid, req1_x, req1_y,
    input  mul_ans,
    output req0_ready, req1_ready,
    output res0_valid, res0_ans, res1_valid, res1_ans,
    output mul_px, mul_py,
    output busy
  );

  modport master (
    output req0_valid, req0_x, req0_y,
    output req1_valid, req1_x, req1_y,
    output mul_ans,
    input  req0_ready, req1_ready,
    input  res0_valid, res0_ans, res1_valid, res1_ans,
    input  mul_px, mul_py,
    input  busy
  );

endinterface

// File: rtl/mul_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the grant is combinational and the priority
// pointer only moves when a grant is actually accepted.
module mul_scheduler_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic prefer1_q;
  logic prefer1_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prefer1_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // The requester just served drops to lowest priority for the next tie.
  always_comb begin
    prefer1_d = prefer1_q;
    if (accept_i) begin
      prefer1_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prefer1_q <= 1'b0;
    end else begin
      prefer1_q <= prefer1_d;
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one pipelined multiplier between the manual and sweep requesters and
// routes each product back to its issuer using a tag that travels with it.
module mul_scheduler
  import mul_scheduler_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT,
  parameter int W   = W_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mul_scheduler_if.slave bus
);

  logic [1:0]     reqMasked;
  logic [1:0]     gnt;
  logic           transfer;
  logic [W-1:0]   grantX;
  logic [W-1:0]   grantY;

  logic [W-1:0]   mulPx_q;
  logic [W-1:0]   mulPy_q;

  tag_t           tagIn_d;
  tag_t [LAT:0]   tagPipe_q;
  tag_t           tagOut;
  logic           busyAny;

  logic           res0Valid_q;
  logic           res1Valid_q;
  logic [2*W-1:0] res0Ans_q;
  logic [2*W-1:0] res1Ans_q;

  // Requests are masked during reset so no requester sees a ready it cannot use.
  assign reqMasked = {bus.req1_valid, bus.req0_valid} & {2{rst_ni}};

  mul_scheduler_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (reqMasked),
    .accept_i (transfer),
    .gnt_o    (gnt)
  );

  assign transfer       = |gnt;
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  assign grantX = gnt[1] ? bus.req1_x : bus.req0_x;
  assign grantY = gnt[1] ? bus.req1_y : bus.req0_y;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mulPx_q <= '0;
      mulPy_q <= '0;
    end else if (transfer) begin
      mulPx_q <= grantX;
      mulPy_q <= grantY;
    end
  end

  assign bus.mul_px = mulPx_q;
  assign bus.mul_py = mulPy_q;

  always_comb begin
    tagIn_d = TAG_EMPTY;
    if (transfer) begin
      tagIn_d = '{valid: 1'b1, id: gnt_to_id(gnt)};
    end
  end

  // Stage 0 pairs with the operand register; the remaining LAT stages track
  // the multiplier itself, so the last stage lines up with a valid mul_ans.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tagPipe_q <= '0;
    end else begin
      tagPipe_q <= {tagPipe_q[LAT-1:0], tagIn_d};
    end
  end

  assign tagOut = tagPipe_q[LAT];

  always_comb begin
    busyAny = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      busyAny = busyAny | tagPipe_q[i].valid;
    end
  end

  assign bus.busy = busyAny;

  // Only the port named by the tag captures the product; the other holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res0Valid_q <= 1'b0;
      res1Valid_q <= 1'b0;
      res0Ans_q   <= '0;
      res1Ans_q   <= '0;
    end else begin
      res0Valid_q <= 1'b0;
      res1Valid_q <= 1'b0;
      if (tagOut.valid) begin
        if (tagOut.id == ID_MANUAL) begin
          res0Valid_q <= 1'b1;
          res0Ans_q   <= bus.mul_ans;
        end else begin
          res1Valid_q <= 1'b1;
          res1Ans_q   <= bus.mul_ans;
        end
      end
    end
  end

  assign bus.res0_valid = res0Valid_q;
  assign bus.res1_valid = res1Valid_q;
  assign bus.res0_ans   = res0Ans_q;
  assign bus.res1_ans   = res1Ans_q;

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with a behavioural LAT-cycle multiplier;
// results are captured by a monitor and compared against hand-computed values.
module tb_mul_scheduler;

  localparam int LAT = 4;
  localparam int W   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mul_scheduler_if #(.W(W)) bus ();

  mul_scheduler #(.LAT(LAT), .W(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [2*W-1:0] mulPipe [LAT];

  always @(posedge clk) begin
    mulPipe[0] <= 16'(bus.mul_px) * 16'(bus.mul_py);
    for (int i = 1; i < LAT; i++) mulPipe[i] <= mulPipe[i-1];
  end

  assign bus.mul_ans = mulPipe[LAT-1];

  typedef struct {
    logic        id;
    logic [15:0] ans;
    int          cyc;
    logic        busy;
  } res_t;

  res_t resQ[$];

  // Every result pulse is logged with its edge number and the busy level.
  always @(negedge clk) begin
    if (rst_n && (bus.res0_valid || bus.res1_valid)) begin
      res_t e;
      checks++;
      if (bus.res0_valid && bus.res1_valid) begin
        errors++;
        $display("[TB] FAIL both_res_valid: got res0_valid=1 res1_valid=1, expected at most one");
      end
      e.id   = bus.res1_valid;
      e.ans  = bus.res1_valid ? bus.res1_ans : bus.res0_ans;
      e.cyc  = cyc;
      e.busy = bus.busy;
      resQ.push_back(e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_x = '0; bus.req0_y = '0;
    bus.req1_x = '0; bus.req1_y = '0;
  endtask

  task automatic applyReset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Compare the logged results against an expected list of (id, ans).
  task automatic checkResults(input string name, input int n0, input int cnt,
                              input logic ids[8], input logic [15:0] anss[8]);
    checks++;
    if (resQ.size() != cnt) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d results, expected %0d", name, resQ.size(), cnt);
    end
    for (int i = 0; i < cnt && i < resQ.size(); i++) begin
      logic expBusy;
      expBusy = (i != cnt - 1);
      checks++;
      if (resQ[i].id !== ids[i] || resQ[i].ans !== anss[i] ||
          resQ[i].cyc != n0 + LAT + 1 + i || resQ[i].busy !== expBusy) begin
        errors++;
        $display("[TB] FAIL %s_res%0d: got id=%0d ans=%h edge=%0d busy=%0d, expected id=%0d ans=%h edge=%0d busy=%0d",
                 name, i, resQ[i].id, resQ[i].ans, resQ[i].cyc, resQ[i].busy,
                 ids[i], anss[i], n0 + LAT + 1 + i, expBusy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b, expected 00", {bus.req1_ready, bus.req0_ready});
    end
    checks++;
    if ({bus.res1_valid, bus.res0_valid, bus.busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_valid_busy: got %b, expected 000", {bus.res1_valid, bus.res0_valid, bus.busy});
    end
    checks++;
    if (bus.res0_ans !== 16'h0 || bus.res1_ans !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_ans: got %h/%h, expected 0000/0000", bus.res0_ans, bus.res1_ans);
    end
    checks++;
    if (bus.mul_px !== 8'h0 || bus.mul_py !== 8'h0) begin
      errors++;
      $display("[TB] FAIL reset_operands: got %h/%h, expected 00/00", bus.mul_px, bus.mul_py);
    end
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n0;
    logic ids[8];
    logic [15:0] anss[8];
    resQ.delete();
    bus.req0_valid = 1'b1; bus.req0_x = 8'd12; bus.req0_y = 8'd13;
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_ready: got %b, expected 01", {bus.req1_ready, bus.req0_ready});
    end
    tick();
    n0 = cyc;
    idle();
    checks++;
    if (bus.mul_px !== 8'd12 || bus.mul_py !== 8'd13 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_issue: got px=%0d py=%0d busy=%0d, expected 12 13 1",
               bus.mul_px, bus.mul_py, bus.busy);
    end
    repeat (LAT + 3) tick();
    ids[0] = 1'b0; anss[0] = 16'd156;
    checkResults("single", n0, 1, ids, anss);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle_busy: got %0d, expected 0", bus.busy);
    end
  endtask

  task automatic test_alternate();
    int n0;
    logic ids[8];
    logic [15:0] anss[8];
    applyReset();
    resQ.delete();
    n0 = cyc + 1;
    bus.req0_valid = 1'b1; bus.req0_x = 8'd3; bus.req0_y = 8'd4;
    bus.req1_valid = 1'b1; bus.req1_x = 8'd5; bus.req1_y = 8'd6;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] expGnt;
      expGnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== expGnt) begin
        errors++;
        $display("[TB] FAIL alternate_grant%0d: got %b, expected %b", i,
                 {bus.req1_ready, bus.req0_ready}, expGnt);
      end
      tick();
      ids[i]  = (i % 2 == 1);
      anss[i] = (i % 2 == 1) ? 16'd30 : 16'd12;
    end
    idle();
    repeat (LAT + 3) tick();
    checkResults("alternate", n0, 8, ids, anss);
  endtask

  task automatic test_back_to_back();
    int n0;
    logic ids[8];
    logic [15:0] anss[8];
    resQ.delete();
    n0 = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      bus.req1_valid = 1'b1; bus.req1_x = 8'(k); bus.req1_y = 8'(k);
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL b2b_ready%0d: got %b, expected 10", k, {bus.req1_ready, bus.req0_ready});
      end
      tick();
      ids[k]  = 1'b1;
      anss[k] = 16'(k * k);
    end
    idle();
    repeat (LAT + 3) tick();
    checkResults("b2b", n0, 8, ids, anss);
  endtask

  task automatic test_boundary();
    int n0;
    logic ids[8];
    logic [15:0] anss[8];
    resQ.delete();
    n0 = cyc + 1;
    bus.req0_valid = 1'b1; bus.req0_x = 8'd255; bus.req0_y = 8'd255;
    tick();
    bus.req0_x = 8'd0; bus.req0_y = 8'd200;
    tick();
    idle();
    repeat (LAT + 3) tick();
    ids[0] = 1'b0; anss[0] = 16'hFE01;
    ids[1] = 1'b0; anss[1] = 16'h0000;
    checkResults("boundary", n0, 2, ids, anss);
  endtask

  task automatic test_reset_midop();
    int n0;
    logic ids[8];
    logic [15:0] anss[8];
    resQ.delete();
    bus.req0_valid = 1'b1; bus.req0_x = 8'd2; bus.req0_y = 8'd3;
    tick();
    bus.req0_x = 8'd4; bus.req0_y = 8'd5;
    tick();
    bus.req0_x = 8'd6; bus.req0_y = 8'd7;
    tick();
    idle();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.res0_valid, bus.res1_valid} !== 3'b000 ||
        bus.mul_px !== 8'h0 || bus.mul_py !== 8'h0 ||
        bus.res0_ans !== 16'h0 || bus.res1_ans !== 16'h0) begin
      errors++;
      $display("[TB] FAIL midop_reset_outputs: got busy=%0d px=%h py=%h ans0=%h ans1=%h, expected all zero",
               bus.busy, bus.mul_px, bus.mul_py, bus.res0_ans, bus.res1_ans);
    end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (LAT + 4) tick();
    checks++;
    if (resQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL midop_discard: got %0d results, expected 0", resQ.size());
    end
    resQ.delete();
    n0 = cyc + 1;
    bus.req0_valid = 1'b1; bus.req0_x = 8'd9; bus.req0_y = 8'd9;
    bus.req1_valid = 1'b1; bus.req1_x = 8'd2; bus.req1_y = 8'd2;
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL midop_first_tie: got %b, expected 01", {bus.req1_ready, bus.req0_ready});
    end
    tick();
    bus.req0_valid = 1'b0;
    tick();
    idle();
    repeat (LAT + 3) tick();
    ids[0] = 1'b0; anss[0] = 16'd81;
    ids[1] = 1'b1; anss[1] = 16'd4;
    checkResults("midop_after", n0, 2, ids, anss);
  endtask

  task automatic test_held();
    int n0;
    logic ids[8];
    logic [15:0] anss[8];
    applyReset();
    resQ.delete();
    n0 = cyc + 1;
    bus.req0_valid = 1'b1; bus.req0_x = 8'd3; bus.req0_y = 8'd3;
    tick();
    bus.req0_x = 8'd7; bus.req0_y = 8'd8;
    bus.req1_valid = 1'b1; bus.req1_x = 8'd9; bus.req1_y = 8'd10;
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL held_req1_wins: got %b, expected 10", {bus.req1_ready, bus.req0_ready});
    end
    tick();
    bus.req1_valid = 1'b0;
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL held_req0_next: got %b, expected 01", {bus.req1_ready, bus.req0_ready});
    end
    tick();
    idle();
    repeat (LAT + 3) tick();
    ids[0] = 1'b0; anss[0] = 16'd9;
    ids[1] = 1'b1; anss[1] = 16'd90;
    ids[2] = 1'b0; anss[2] = 16'd56;
    checkResults("held", n0, 3, ids, anss);
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_alternate();
    test_back_to_back();
    test_boundary();
    test_reset_midop();
    test_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
